timer_unit: RTL

- Memory-mapped countdown timer; one instance sits directly downstream of the processor-side address bridge as timer0, and a second as timer1.
- Consumes the bridge's device address, write data and single-bit write enable; returns read data to the bridge's read mux.
- Raises an interrupt request to the CP0 interrupt input when its count expires.
- Two modes: one-shot with a held interrupt, and auto-reload with a single-cycle interrupt pulse.

---
 rtl/timer_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/timer_unit.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Raises a maskable level interrupt when the count expires.
module timer_unit #(
  parameter int COUNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_e             state_q;
  logic [3:0]         ctrl_q;
  logic [COUNT_W-1:0] preset_q;
  logic [COUNT_W-1:0] count_q;
  logic               irq_q;

  logic [1:0] off;
  logic       en;
  logic       reload;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       unused_bits;

  assign off       = Addr[3:2];
  assign en        = ctrl_q[0];
  assign reload    = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl   = WE && (off == 2'd0);
  assign wr_preset = WE && (off == 2'd1);

  // Only Addr[3:2] is decoded; upper Din bits may be dropped.
  assign unused_bits = ^{Addr[31:4], Addr[1:0], Din};

  // Countdown FSM; software writes are applied last so they win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en) state_q <= LOAD;
        end
        LOAD: begin
          count_q <= preset_q;
          irq_q   <= 1'b0;
          state_q <= CNT;
        end
        CNT: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (count_q > ONE) begin
            count_q <= count_q - ONE;
          end else begin
            count_q <= '0;
            irq_q   <= 1'b1;
            state_q <= INT;
          end
        end
        INT: begin
          if (reload) irq_q <= 1'b0;
          else        ctrl_q[0] <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (wr_ctrl) begin
        ctrl_q <= Din[3:0];
        irq_q  <= 1'b0;
      end
      if (wr_preset) preset_q <= Din[COUNT_W-1:0];
    end
  end

  // Zero-latency read mux, narrow registers zero-extended.
  always_comb begin
    Dout = '0;
    unique case (off)
      2'd0:    Dout[3:0] = ctrl_q;
      2'd1:    Dout[COUNT_W-1:0] = preset_q;
      2'd2:    Dout[COUNT_W-1:0] = count_q;
      default: Dout = '0;
    endcase
  end

  assign IRQ = ctrl_q[3] & irq_q;

endmodule
